// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from the 8-deep byte FIFO and sends each one as an 8N1 frame.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit, which makes the frame 8E1.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16  // must be >= 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam int            BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    frames_q, frames_d;
    logic          tx_q, tx_d;
    logic          baud_last;

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        frames_d = frames_q;
        tx_d     = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) state_d = S_READ;
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // FIFO output is registered, so the popped byte is valid only now
                shift_d = fifo_data;
                baud_d  = '0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_d   = '0;
                    frames_d = frames_q + 8'd1;
                    state_d  = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // tx is registered from the next state, so it lines up with the state register
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[bit_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = ^shift_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            frames_q <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            frames_q <= frames_d;
            tx_q     <= tx_d;
        end
    end

    assign fifo_rd_en  = (state_q == S_READ);
    assign busy        = (state_q != S_IDLE);
    assign tx          = tx_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue-based FIFO model, a line-sampling frame capture, and a byte-level frame model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int WAIT_LIMIT = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    logic [7:0] fq[$];

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO: data_out follows the cycle after a sampled pop
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    always @(negedge clk) if (fifo_rd_en === 1'b1) rd_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start bit, data LSB first, optional even parity, then the stop bit
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // Waits for a start bit, then samples every cycle of the frame; gap = idle-high samples before start
    task automatic capture_frame(output logic [10:0] bits, output bit stable, output int gap, output bit got);
        bits = '1; stable = 1'b1; gap = 0; got = 1'b0;
        for (int t = 0; t < WAIT_LIMIT; t++) begin
            @(negedge clk);
            if (tx === 1'b0) begin got = 1'b1; break; end
            gap++;
        end
        if (!got) return;
        for (int k = 0; k < NBITS; k++)
            for (int c = 0; c < CPB; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (c == 0) bits[k] = tx;
                else if (tx !== bits[k]) stable = 1'b0;
            end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;  // 8N1 line levels, bit k is the k-th bit sent
        logic       par;
    } vec_t;

    initial begin
        vec_t        tbl[5];
        logic [10:0] bits, exp;
        logic [7:0]  b, sent[$];
        bit          stable, got;
        int          gap, rd0, n, exp_frames;
        bit          ok;

        tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
        tbl[1] = '{8'h07, 10'b1000001110, 1'b1};
        tbl[2] = '{8'h03, 10'b1000000110, 1'b0};
        tbl[3] = '{8'h00, 10'b1000000000, 1'b0};
        tbl[4] = '{8'h3C, 10'b1001111000, 1'b0};

        rst_n = 1'b0; enable = 1'b0; exp_frames = 0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1); chk("reset_busy", busy, 0);
        chk("reset_rd_en", fifo_rd_en, 0); chk("reset_frames", frames_sent, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-byte frames from the vector table
        for (int i = 0; i < 5; i++) begin
`ifdef UART_TX_PARITY_EN
            exp = {1'b1, tbl[i].par, tbl[i].line[8:0]};
`else
            exp = {1'b1, tbl[i].line};
`endif
            rd0 = rd_cnt;
            fq.push_back(tbl[i].data);
            enable = 1'b1;
            capture_frame(bits, stable, gap, got);
            chk($sformatf("tbl%0d_start", i), got, 1);
            chk($sformatf("tbl%0d_bits", i), bits, exp);
            chk($sformatf("tbl%0d_stable", i), stable, 1);
            @(negedge clk);
            exp_frames++;
            chk($sformatf("tbl%0d_frames", i), frames_sent, exp_frames[7:0]);
            chk($sformatf("tbl%0d_busy_after", i), busy, 0);
            chk($sformatf("tbl%0d_tx_after", i), tx, 1);
            chk($sformatf("tbl%0d_pops", i), rd_cnt - rd0, 1);
            enable = 1'b0;
            @(negedge clk);
        end

        // Back-to-back: three queued bytes, fixed 3-cycle idle gap
        sent = '{8'h00, 8'hFF, 8'h3C};
        foreach (sent[j]) fq.push_back(sent[j]);
        enable = 1'b1;
        for (int j = 0; j < 3; j++) begin
            capture_frame(bits, stable, gap, got);
            chk($sformatf("b2b%0d_bits", j), bits, model_frame(sent[j]));
            chk($sformatf("b2b%0d_stable", j), stable & got, 1);
            if (j > 0) chk($sformatf("b2b%0d_gap", j), gap, 3);
            exp_frames++;
        end
        @(negedge clk);
        chk("b2b_frames", frames_sent, exp_frames[7:0]);
        chk("b2b_fifo_empty", fq.size(), 0);

        // Randomized bursts against the byte-level model
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(2, 5);
            sent.delete();
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                sent.push_back(b);
                fq.push_back(b);
            end
            for (int j = 0; j < n; j++) begin
                capture_frame(bits, stable, gap, got);
                chk($sformatf("rnd%0d_%0d_bits", r, j), bits, model_frame(sent[j]));
                chk($sformatf("rnd%0d_%0d_stable", r, j), stable & got, 1);
                if (j > 0) chk($sformatf("rnd%0d_%0d_gap", r, j), gap, 3);
                exp_frames++;
            end
            @(negedge clk);
            chk($sformatf("rnd%0d_frames", r), frames_sent, exp_frames[7:0]);
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end

        // Enable dropped 10 cycles into the first frame
        enable = 1'b0;
        @(negedge clk);
        sent = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (sent[j]) fq.push_back(sent[j]);
        rd0 = rd_cnt;
        @(negedge clk);
        enable = 1'b1;
        fork
            capture_frame(bits, stable, gap, got);
            begin repeat (10) @(negedge clk); enable = 1'b0; end
        join
        chk("en_first_bits", bits, model_frame(8'h11));
        exp_frames++;
        repeat (60) @(negedge clk);
        chk("en_hold_pops", rd_cnt - rd0, 1);
        chk("en_hold_busy", busy, 0);
        chk("en_hold_tx", tx, 1);
        chk("en_hold_frames", frames_sent, exp_frames[7:0]);
        enable = 1'b1;
        for (int j = 1; j < 4; j++) begin
            capture_frame(bits, stable, gap, got);
            chk($sformatf("en_resume%0d_bits", j), bits, model_frame(sent[j]));
            exp_frames++;
        end
        @(negedge clk);
        chk("en_total_pops", rd_cnt - rd0, 4);

        // Empty FIFO with enable high: nothing happens
        rd0 = rd_cnt; ok = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        chk("empty_idle", ok, 1);
        chk("empty_no_pop", rd_cnt - rd0, 0);

        // frames_sent wraps 255 -> 0
        n = 256 - (exp_frames % 256);
        for (int j = 0; j < n; j++) fq.push_back(8'($urandom));
        ok = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (fq.size() == 0 && busy === 1'b0) begin ok = 1'b1; break; end
        end
        chk("wrap_drained", ok, 1);
        chk("wrap_frames", frames_sent, 0);

        // Asynchronous reset mid-frame
        fq.push_back(8'h5A);
        got = 1'b0;
        for (int t = 0; t < WAIT_LIMIT; t++) begin
            @(negedge clk);
            if (tx === 1'b0) begin got = 1'b1; break; end
        end
        chk("rst_frame_started", got, 1);
        repeat (15) @(negedge clk);
        chk("rst_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_rd_en", fifo_rd_en, 0);
        chk("rst_async_frames", frames_sent, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd0 = rd_cnt;
        repeat (20) @(negedge clk);
        chk("rst_after_tx", tx, 1);
        chk("rst_after_no_pop", rd_cnt - rd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
